traffic_sink: RTL and testbench

Ejection-side endpoint for one router: consumes flits leaving the router's local output port (port 0) and returns their credits after the configured credit delay. It reassembles packets per VC, checks protocol and destination, and accumulates packet and latency statistics. It is the counterpart of the `traffic` injection block and is instantiated once per router in the top-level generate loop. It is driven by the same op/data sequencing as the routers.

---
 rtl/traffic_sink.sv | 143 ++++++++++++++
 tb/tb_traffic_sink.sv | 134 +++++++++++++
 2 files changed

// File: rtl/traffic_sink.sv
// Ejection endpoint: sinks local-port flits, returns credits after a programmable
// delay, reassembles packets per VC and accumulates packet/latency statistics.
module traffic_sink #(
  parameter int VC_BITS = 2,
  parameter int ID_W    = 4,
  parameter int CD_W    = 4,
  parameter int OP_W    = 3,
  parameter logic [OP_W-1:0] OP_NOP   = OP_W'(0),
  parameter logic [OP_W-1:0] OP_INIT  = OP_W'(1),
  parameter logic [OP_W-1:0] OP_EJECT = OP_W'(3),
  parameter logic [OP_W-1:0] OP_TICK  = OP_W'(5),
  parameter int DATA_W  = 24,
  parameter int FLIT_W  = 25
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OP_W-1:0]     op,
  input  logic [DATA_W-1:0]   data,
  input  logic [FLIT_W-1:0]   flit_in,
  output logic [VC_BITS:0]    credit_out,
  output logic                done,
  output logic [2:0]          err,
  output logic [15:0]         pkt_count,
  output logic [15:0]         flit_count,
  output logic [31:0]         lat_sum,
  output logic [15:0]         lat_max
);
  localparam int NUM_VC = 2**VC_BITS;
  localparam int NSLOT  = 2**CD_W - 1;
  localparam int HB     = VC_BITS + 1;
  localparam int TB     = VC_BITS + 2;
  localparam int DB     = VC_BITS + 3;
  localparam int TSB    = DB + ID_W;

  typedef enum logic {IDLE, BUSY} vc_state_e;

  logic [15:0]                  exp_q, exp_d, pkt_q, pkt_d, flit_q, flit_d;
  logic [15:0]                  lat_max_q, lat_max_d, cyc_q, cyc_d;
  logic [31:0]                  lat_sum_q, lat_sum_d;
  logic [ID_W-1:0]              id_q, id_d;
  logic [CD_W-1:0]              cd_q, cd_d;
  logic [2:0]                   err_q, err_d;
  logic                         done_q, done_d;
  logic [VC_BITS:0]             cred_q, cred_d;
  logic [NSLOT-1:0][VC_BITS:0]  pipe_q, pipe_d;
  vc_state_e                    vc_q [NUM_VC];
  vc_state_e                    vc_d [NUM_VC];

  logic                fvld, fhead, ftail, cmp, all_idle;
  logic [VC_BITS-1:0]  fvc;
  logic [ID_W-1:0]     fdst;
  logic [15:0]         fts, lat;
  logic [32:0]         sum;
  logic [CD_W-1:0]     dcd;

  assign fvld  = flit_in[0];
  assign fvc   = flit_in[VC_BITS:1];
  assign fhead = flit_in[HB];
  assign ftail = flit_in[TB];
  assign fdst  = flit_in[DB +: ID_W];
  assign fts   = flit_in[TSB +: 16];
  assign dcd   = data[20 +: CD_W];

  always_comb begin
    exp_d = exp_q; id_d = id_q; cd_d = cd_q;
    pkt_d = pkt_q; flit_d = flit_q; lat_sum_d = lat_sum_q; lat_max_d = lat_max_q;
    err_d = err_q; cyc_d = cyc_q; pipe_d = pipe_q; cred_d = cred_q;
    vc_d = vc_q;
    cmp = 1'b0;
    lat = cyc_q - fts;
    sum = {1'b0, lat_sum_q} + 33'(lat);
    all_idle = 1'b1;
    for (int i = 0; i < NUM_VC; i++) if (vc_q[i] != IDLE) all_idle = 1'b0;
    // done tracks the state as of the start of this clock, so it lags by one
    done_d = (pkt_q == exp_q) && all_idle && (pipe_q == '0) && !cred_q[0];
    case (op)
      OP_INIT: begin
        exp_d = data[15:0];
        id_d  = data[16 +: ID_W];
        cd_d  = (dcd == '0) ? CD_W'(1) : dcd;
        pkt_d = '0; flit_d = '0; lat_sum_d = '0; lat_max_d = '0;
        err_d = '0; cyc_d = '0; pipe_d = '0; cred_d = '0; done_d = 1'b0;
        for (int i = 0; i < NUM_VC; i++) vc_d[i] = IDLE;
      end
      OP_EJECT: if (fvld) begin
        flit_d = flit_q + 16'd1;
        for (int k = 0; k < NSLOT; k++)
          if (k == int'(cd_q) - 1) pipe_d[k] = {fvc, 1'b1};
        if (fdst != id_q) err_d[1] = 1'b1;
        case (vc_q[fvc])
          IDLE: begin
            if (!fhead) err_d[0] = 1'b1;
            else if (ftail) cmp = 1'b1;
            else vc_d[fvc] = BUSY;
          end
          default: begin
            if (fhead) err_d[0] = 1'b1;
            if (ftail) begin
              cmp = 1'b1;
              vc_d[fvc] = IDLE;
            end
          end
        endcase
        if (cmp) begin
          pkt_d     = pkt_q + 16'd1;
          lat_sum_d = sum[32] ? '1 : sum[31:0];
          if (lat > lat_max_q) lat_max_d = lat;
          if (pkt_q >= exp_q) err_d[2] = 1'b1;
        end
      end
      OP_TICK: begin
        cred_d = pipe_q[0];
        for (int k = 0; k < NSLOT - 1; k++) pipe_d[k] = pipe_q[k+1];
        pipe_d[NSLOT-1] = '0;
        cyc_d = cyc_q + 16'd1;
      end
      OP_NOP: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q <= '0; id_q <= '0; cd_q <= CD_W'(1);
      pkt_q <= '0; flit_q <= '0; lat_sum_q <= '0; lat_max_q <= '0;
      err_q <= '0; cyc_q <= '0; pipe_q <= '0; cred_q <= '0; done_q <= 1'b0;
      for (int i = 0; i < NUM_VC; i++) vc_q[i] <= IDLE;
    end else begin
      exp_q <= exp_d; id_q <= id_d; cd_q <= cd_d;
      pkt_q <= pkt_d; flit_q <= flit_d; lat_sum_q <= lat_sum_d; lat_max_q <= lat_max_d;
      err_q <= err_d; cyc_q <= cyc_d; pipe_q <= pipe_d; cred_q <= cred_d; done_q <= done_d;
      for (int i = 0; i < NUM_VC; i++) vc_q[i] <= vc_d[i];
    end
  end

  assign credit_out = cred_q;
  assign done       = done_q;
  assign err        = err_q;
  assign pkt_count  = pkt_q;
  assign flit_count = flit_q;
  assign lat_sum    = lat_sum_q;
  assign lat_max    = lat_max_q;
endmodule

// File: tb/tb_traffic_sink.sv
// Directed bench for traffic_sink: credits, reassembly, errors, stats and done.
module tb_traffic_sink;
  localparam logic [2:0] NOP = 3'd0, INIT = 3'd1, EJ = 3'd3, TK = 3'd5;

  logic        clk = 1'b0, rst = 1'b1;
  logic [2:0]  op = NOP;
  logic [23:0] data = '0;
  logic [24:0] flit_in = '0;
  logic [2:0]  credit_out, err;
  logic        done;
  logic [15:0] pkt_count, flit_count, lat_max;
  logic [31:0] lat_sum;
  int n_chk = 0, n_fail = 0;

  traffic_sink dut (
    .clk(clk), .rst(rst), .op(op), .data(data), .flit_in(flit_in),
    .credit_out(credit_out), .done(done), .err(err), .pkt_count(pkt_count),
    .flit_count(flit_count), .lat_sum(lat_sum), .lat_max(lat_max)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [24:0] fl(input int vc, input bit h, input bit t,
                                     input int dst, input int ts);
    logic [1:0] v; logic [3:0] d; logic [15:0] s;
    v = vc[1:0]; d = dst[3:0]; s = ts[15:0];
    return {s, d, t, h, v, 1'b1};
  endfunction

  function automatic logic [23:0] cfg(input int cd, input int id, input int ex);
    logic [3:0] c; logic [3:0] i; logic [15:0] e;
    c = cd[3:0]; i = id[3:0]; e = ex[15:0];
    return {c, i, e};
  endfunction

  task automatic step(input logic [2:0] o, input logic [23:0] d, input logic [24:0] f);
    op = o; data = d; flit_in = f;
    @(posedge clk); #1;
    op = NOP; flit_in = '0;
  endtask

  task automatic tick(); step(TK, '0, '0); endtask
  task automatic nop();  step(NOP, '0, '0); endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cred", credit_out, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
    chk("rst_pkt", pkt_count, 0);   chk("rst_flit", flit_count, 0);
    chk("rst_lsum", lat_sum, 0);    chk("rst_lmax", lat_max, 0);
    rst = 1'b0;

    // expected=2, id=3, delay=2; 3-flit packet on vc1
    step(INIT, cfg(2, 3, 2), '0);
    chk("init_done", done, 0); chk("init_pkt", pkt_count, 0);
    step(EJ, '0, fl(1, 1, 0, 3, 0));
    tick();                              chk("cred_t1", credit_out, 0);
    step(EJ, '0, fl(1, 0, 0, 3, 0));
    tick();                              chk("cred_head", credit_out, 3'b011);
    step(EJ, '0, fl(1, 0, 1, 3, 0));
    chk("p1_pkt", pkt_count, 1); chk("p1_flit", flit_count, 3);
    chk("p1_lsum", lat_sum, 2);  chk("p1_lmax", lat_max, 2); chk("p1_err", err, 0);
    chk("cred_hold", credit_out, 3'b011);
    tick();                              chk("cred_body", credit_out, 3'b011);
    tick();                              chk("cred_tail", credit_out, 3'b011);
    tick();                              chk("cred_clr", credit_out, 0);
    chk("p1_done", done, 0);

    // second packet at cycle 5 with ts=1 -> lat 4
    step(EJ, '0, fl(0, 1, 1, 3, 1));
    chk("p2_pkt", pkt_count, 2); chk("p2_lsum", lat_sum, 6); chk("p2_lmax", lat_max, 4);
    tick(); tick();                      chk("p2_cred", credit_out, 3'b001);
    chk("p2_done_busy", done, 0);
    tick();                              chk("p2_done_lag", done, 0);
    nop();                               chk("p2_done", done, 1);

    // extra packet -> overflow, done falls a clock later
    step(EJ, '0, fl(0, 1, 1, 3, 8));
    chk("ovf_err", err, 3'b100); chk("ovf_pkt", pkt_count, 3);
    nop();                               chk("ovf_done", done, 0);

    // delay 0 behaves as 1; protocol and dst errors
    step(INIT, cfg(0, 3, 2), '0);
    chk("i2_err", err, 0); chk("i2_pkt", pkt_count, 0); chk("i2_cred", credit_out, 0);
    step(EJ, '0, fl(2, 1, 1, 3, 0));
    chk("d0_pre", credit_out, 0);
    tick();                              chk("d0_cred", credit_out, 3'b101);
    step(EJ, '0, fl(2, 0, 0, 3, 0));
    chk("body_err", err, 3'b001); chk("body_pkt", pkt_count, 1); chk("body_flit", flit_count, 2);
    tick();                              chk("body_cred", credit_out, 3'b101);
    step(EJ, '0, fl(3, 1, 1, 5, 0));
    chk("dst_err", err, 3'b011); chk("dst_pkt", pkt_count, 2);

    // interleaved vc0/vc1, delay 3, wrapped timestamp on vc1 tail
    step(INIT, cfg(3, 3, 2), '0);
    step(EJ, '0, fl(0, 1, 0, 3, 0)); tick();
    step(EJ, '0, fl(1, 1, 0, 3, 1)); tick();
    step(EJ, '0, fl(1, 0, 1, 3, 16'hFFFE)); tick();
    step(EJ, '0, fl(0, 0, 1, 3, 0));
    chk("il_pkt", pkt_count, 2); chk("il_flit", flit_count, 4); chk("il_err", err, 0);
    chk("il_lsum", lat_sum, 7);  chk("il_lmax", lat_max, 4);    chk("il_done", done, 0);
    tick(); tick(); tick();              chk("il_cred", credit_out, 3'b001);
    chk("il_done_pipe", done, 0);
    tick();                              chk("il_cred_clr", credit_out, 0);
    chk("il_done_lag", done, 0);
    nop();                               chk("il_done_set", done, 1);

    // INIT mid-packet with credits in flight; expected=0
    step(EJ, '0, fl(0, 1, 0, 3, 0));
    step(INIT, cfg(1, 3, 0), '0);
    chk("mid_flit", flit_count, 0); chk("mid_done0", done, 0);
    nop();                               chk("mid_done1", done, 1);
    tick(); tick(); tick(); tick();      chk("mid_nostale", credit_out, 0);
    step(EJ, '0, fl(0, 0, 1, 3, 0));
    chk("mid_vcclr", err, 3'b001); chk("mid_pkt", pkt_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
